// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, message-atomic sharing of one txuart between NPORTS byte streams.
// Optional forced release of an idle lock is compiled in with `define OPT_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
   parameter int          NPORTS   = 4,
   parameter int          LGNPORTS = 2,
   parameter logic [23:0] TIMEOUT  = 24'd86800
) (
   input  logic                  i_clk,
   input  logic                  i_reset_n,
   input  logic [NPORTS-1:0]     i_valid,
   input  logic [8*NPORTS-1:0]   i_data,
   input  logic [NPORTS-1:0]     i_last,
   output logic [NPORTS-1:0]     o_ready,
   output logic                  o_tx_stb,
   output logic [7:0]            o_tx_data,
   input  logic                  i_tx_busy,
   output logic [LGNPORTS-1:0]   o_grant,
   output logic                  o_active,
   output logic                  o_timeout
);

   typedef enum logic {S_IDLE, S_LOCKED} state_t;

   state_t              state;
   logic [LGNPORTS-1:0] grant;
   logic [LGNPORTS-1:0] last_grant;
   logic [LGNPORTS-1:0] pick;
   logic [7:0]          port_byte [NPORTS];
   logic                xfer;

   // First requester at or after last_grant+1, wrapping modulo NPORTS.
   function automatic logic [LGNPORTS-1:0] rr_pick(input logic [NPORTS-1:0] v,
                                                   input logic [LGNPORTS-1:0] last);
      logic [LGNPORTS-1:0] idx;
      logic                found;
      rr_pick = '0;
      found   = 1'b0;
      for (int i = 1; i <= NPORTS; i++) begin
         idx = LGNPORTS'((int'(last) + i) % NPORTS);
         if (!found && v[idx]) begin
            rr_pick = idx;
            found   = 1'b1;
         end
      end
   endfunction

   always_comb begin
      for (int k = 0; k < NPORTS; k++) begin
         port_byte[k] = i_data[8*k +: 8];
      end
   end

   assign pick = rr_pick(i_valid, last_grant);
   assign xfer = (state == S_LOCKED) && i_valid[grant] && !i_tx_busy;

   // Transmit path stays combinational so back-to-back bytes keep txuart saturated;
   // every output is held at its reset value while reset is asserted.
   always_comb begin
      o_ready   = '0;
      o_tx_stb  = 1'b0;
      o_tx_data = 8'h00;
      o_active  = 1'b0;
      if (i_reset_n && (state == S_LOCKED)) begin
         o_active       = 1'b1;
         o_ready[grant] = !i_tx_busy;
         o_tx_stb       = i_valid[grant] && !i_tx_busy;
         o_tx_data      = port_byte[grant];
      end
   end

   assign o_grant = i_reset_n ? grant : '0;

`ifdef OPT_ARB_TIMEOUT_EN
   logic [23:0] idle_cnt;
   logic        timeout_q;

   assign o_timeout = i_reset_n && timeout_q;
`else
   logic unused_timeout;

   assign unused_timeout = ^TIMEOUT;
   assign o_timeout      = 1'b0;
`endif

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         state      <= S_IDLE;
         grant      <= '0;
         last_grant <= LGNPORTS'(NPORTS - 1);
`ifdef OPT_ARB_TIMEOUT_EN
         idle_cnt   <= '0;
         timeout_q  <= 1'b0;
`endif
      end else begin
`ifdef OPT_ARB_TIMEOUT_EN
         timeout_q <= 1'b0;
`endif
         case (state)
            S_IDLE: begin
               if (|i_valid) begin
                  grant <= pick;
                  state <= S_LOCKED;
`ifdef OPT_ARB_TIMEOUT_EN
                  idle_cnt <= '0;
`endif
               end
            end
            S_LOCKED: begin
               if (xfer) begin
                  if (i_last[grant]) begin
                     last_grant <= grant;
                     state      <= S_IDLE;
                  end
`ifdef OPT_ARB_TIMEOUT_EN
                  idle_cnt <= '0;
`endif
               end
`ifdef OPT_ARB_TIMEOUT_EN
               // A stalled owner is only counted while it presents nothing; busy stalls are not idle.
               else if (!i_valid[grant]) begin
                  if (idle_cnt == TIMEOUT - 24'd1) begin
                     last_grant <= grant;
                     state      <= S_IDLE;
                     timeout_q  <= 1'b1;
                     idle_cnt   <= '0;
                  end else begin
                     idle_cnt <= idle_cnt + 24'd1;
                  end
               end
`endif
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
